// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard-stall controller for a 5-stage pipeline.
// Build option: define FORWARDING_EN to enable EX operand forwarding; otherwise dependents stall.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Shadow pipeline state
  logic              ex_valid_r, ex_regwrite_r, ex_memread_r, ex_use_rs_r, ex_use_rt_r;
  logic [REG_AW-1:0] ex_rd_r, ex_rs_r, ex_rt_r;
  logic              mem_valid_r, mem_regwrite_r, mem_memread_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic              wb_valid_r, wb_regwrite_r, wb_memread_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              ex_nxt_valid_s, ex_nxt_regwrite_s, ex_nxt_memread_s;
  logic              ex_nxt_use_rs_s, ex_nxt_use_rt_s;
  logic [REG_AW-1:0] ex_nxt_rd_s, ex_nxt_rs_s, ex_nxt_rt_s;
  logic              ex_live_s, mem_live_s, wb_live_s;
  logic              stall_s, bubble_s;
  logic              unused_s;

  // True when the ID instruction reads register rd through a used source port.
  function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                    input logic use_rs, input logic [REG_AW-1:0] rs,
                                    input logic use_rt, input logic [REG_AW-1:0] rt);
    return (use_rs && (rs == rd)) || (use_rt && (rt == rd));
  endfunction

  assign ex_live_s  = ex_valid_r  & ex_regwrite_r  & (ex_rd_r  != REG_ZERO);
  assign mem_live_s = mem_valid_r & mem_regwrite_r & (mem_rd_r != REG_ZERO);
  assign wb_live_s  = wb_valid_r  & wb_regwrite_r  & (wb_rd_r  != REG_ZERO);

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time.
  assign stall_s = id_valid_i & ~flush_i & ex_live_s & ex_memread_r &
                   id_reads(ex_rd_r, id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i);
`else
  // Without forwarding, wait until the producer has reached WB.
  assign stall_s = id_valid_i & ~flush_i &
                   ((ex_live_s  & id_reads(ex_rd_r,  id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i)) |
                    (mem_live_s & id_reads(mem_rd_r, id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i)));
`endif

  assign bubble_s = stall_s | flush_i;

  // Next EX contents: captured ID fields, or an all-zero bubble.
  always_comb begin
    ex_nxt_valid_s    = 1'b0;
    ex_nxt_regwrite_s = 1'b0;
    ex_nxt_memread_s  = 1'b0;
    ex_nxt_use_rs_s   = 1'b0;
    ex_nxt_use_rt_s   = 1'b0;
    ex_nxt_rd_s       = REG_ZERO;
    ex_nxt_rs_s       = REG_ZERO;
    ex_nxt_rt_s       = REG_ZERO;
    if (!bubble_s) begin
      ex_nxt_valid_s    = id_valid_i;
      ex_nxt_regwrite_s = id_regwrite_i;
      ex_nxt_memread_s  = id_memread_i;
      ex_nxt_use_rs_s   = id_use_rs_i;
      ex_nxt_use_rt_s   = id_use_rt_i;
      ex_nxt_rd_s       = id_rd_i;
      ex_nxt_rs_s       = id_rs_i;
      ex_nxt_rt_s       = id_rt_i;
    end else begin
      ex_nxt_valid_s    = 1'b0;
    end
  end

  // Shadow pipeline advance: WB <= MEM <= EX <= ID/bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_r     <= 1'b0;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      ex_use_rs_r    <= 1'b0;
      ex_use_rt_r    <= 1'b0;
      ex_rd_r        <= REG_ZERO;
      ex_rs_r        <= REG_ZERO;
      ex_rt_r        <= REG_ZERO;
      mem_valid_r    <= 1'b0;
      mem_regwrite_r <= 1'b0;
      mem_memread_r  <= 1'b0;
      mem_rd_r       <= REG_ZERO;
      wb_valid_r     <= 1'b0;
      wb_regwrite_r  <= 1'b0;
      wb_memread_r   <= 1'b0;
      wb_rd_r        <= REG_ZERO;
    end else begin
      ex_valid_r     <= ex_nxt_valid_s;
      ex_regwrite_r  <= ex_nxt_regwrite_s;
      ex_memread_r   <= ex_nxt_memread_s;
      ex_use_rs_r    <= ex_nxt_use_rs_s;
      ex_use_rt_r    <= ex_nxt_use_rt_s;
      ex_rd_r        <= ex_nxt_rd_s;
      ex_rs_r        <= ex_nxt_rs_s;
      ex_rt_r        <= ex_nxt_rt_s;
      mem_valid_r    <= ex_valid_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_memread_r  <= ex_memread_r;
      mem_rd_r       <= ex_rd_r;
      wb_valid_r     <= mem_valid_r;
      wb_regwrite_r  <= mem_regwrite_r;
      wb_memread_r   <= mem_memread_r;
      wb_rd_r        <= mem_rd_r;
    end
  end

`ifdef FORWARDING_EN
  logic [1:0] fwd_a_r, fwd_b_r;
  logic [1:0] fwd_a_nxt_s, fwd_b_nxt_s;

  // Select for one operand: newest live producer (MEM) beats the older one (WB).
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src,
                                         input logic m_live, input logic [REG_AW-1:0] m_rd,
                                         input logic w_live, input logic [REG_AW-1:0] w_rd);
    logic [1:0] sel;
    if (use_src && m_live && (m_rd == src)) begin
      sel = 2'b01;
    end else if (use_src && w_live && (w_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Selects are precomputed from the state the pipeline moves into, so they come out of flops.
  assign fwd_a_nxt_s = fwd_sel(ex_nxt_use_rs_s, ex_nxt_rs_s, ex_live_s, ex_rd_r, mem_live_s, mem_rd_r);
  assign fwd_b_nxt_s = fwd_sel(ex_nxt_use_rt_s, ex_nxt_rt_s, ex_live_s, ex_rd_r, mem_live_s, mem_rd_r);

  // Registered forwarding selects.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end
  end

  assign fwd_a_o  = fwd_a_r;
  assign fwd_b_o  = fwd_b_r;
  assign unused_s = &{1'b0, mem_memread_r, wb_memread_r, wb_live_s, ex_use_rs_r, ex_use_rt_r,
                      ex_rs_r, ex_rt_r};
`else
  assign fwd_a_o  = 2'b00;
  assign fwd_b_o  = 2'b00;
  assign unused_s = &{1'b0, mem_memread_r, wb_memread_r, wb_live_s, ex_use_rs_r, ex_use_rt_r,
                      ex_rs_r, ex_rt_r, ex_memread_r};
`endif

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_o       = stall_s;
  assign pc_write_o    = ~stall_s;
  assign ifid_write_o  = ~stall_s;
  assign idex_bubble_o = bubble_s;
  assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios plus randomized
// instruction streams compared every cycle against a queue-style pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
  logic          id_use_rs_i, id_use_rt_i, id_regwrite_i, id_memread_i, id_valid_i, flush_i;
  logic [1:0]    fwd_a_o, fwd_b_o;
  logic          stall_o, pc_write_o, ifid_write_o, idex_bubble_o;
  logic [CW-1:0] stall_cnt_o;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_valid_i(id_valid_i), .flush_i(flush_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .idex_bubble_o(idex_bubble_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction record; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB (index = distance from ID).
  typedef struct {
    int valid; int rd; int rw; int mr; int rs; int rt; int urs; int urt;
  } instr_t;

  instr_t pipe[3];
  int     m_cnt;
  int     last_stall;
  int     checks;
  int     errors;

  function automatic instr_t empty_instr();
    instr_t e;
    e.valid = 0; e.rd = 0; e.rw = 0; e.mr = 0; e.rs = 0; e.rt = 0; e.urs = 0; e.urt = 0;
    return e;
  endfunction

  function automatic int writes_reg(instr_t s);
    return (s.valid != 0 && s.rw != 0 && s.rd != 0) ? 1 : 0;
  endfunction

  function automatic int id_needs(int r);
    return ((id_use_rs_i && int'(id_rs_i) == r) || (id_use_rt_i && int'(id_rt_i) == r)) ? 1 : 0;
  endfunction

  // Select = distance of the newest in-flight producer (1 = MEM, 2 = WB), else regfile.
  function automatic int exp_fwd(int use_src, int src);
    if (!FWD || use_src == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (writes_reg(pipe[k]) != 0 && pipe[k].rd == src) return k;
    return 0;
  endfunction

  function automatic int exp_stall();
    if (!id_valid_i || flush_i) return 0;
    if (FWD) return (writes_reg(pipe[0]) != 0 && pipe[0].mr != 0 && id_needs(pipe[0].rd) != 0) ? 1 : 0;
    for (int k = 0; k < 2; k++)
      if (writes_reg(pipe[k]) != 0 && id_needs(pipe[k].rd) != 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int st;
    st = exp_stall();
    chk("fwd_a", int'(fwd_a_o), exp_fwd(pipe[0].urs, pipe[0].rs));
    chk("fwd_b", int'(fwd_b_o), exp_fwd(pipe[0].urt, pipe[0].rt));
    chk("stall", int'(stall_o), st);
    chk("pc_write", int'(pc_write_o), 1 - st);
    chk("ifid_write", int'(ifid_write_o), 1 - st);
    chk("idex_bubble", int'(idex_bubble_o), (st != 0 || flush_i) ? 1 : 0);
    chk("stall_cnt", int'(stall_cnt_o), (m_cnt > CMAX) ? CMAX : m_cnt);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = empty_instr();
    m_cnt = 0;
    last_stall = 0;
  endtask

  task automatic model_step();
    instr_t n;
    int st;
    st = exp_stall();
    last_stall = st;
    if (st != 0) m_cnt++;
    n = empty_instr();
    if (st == 0 && !flush_i) begin
      n.valid = int'(id_valid_i); n.rd = int'(id_rd_i); n.rw = int'(id_regwrite_i);
      n.mr = int'(id_memread_i); n.rs = int'(id_rs_i); n.rt = int'(id_rt_i);
      n.urs = int'(id_use_rs_i); n.urt = int'(id_use_rt_i);
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
  endtask

  task automatic drv(input int v, input int rs, input int urs, input int rt, input int urt,
                     input int rd, input int rw, input int mr);
    id_valid_i = v[0]; id_rs_i = rs[4:0]; id_use_rs_i = urs[0]; id_rt_i = rt[4:0];
    id_use_rt_i = urt[0]; id_rd_i = rd[4:0]; id_regwrite_i = rw[0]; id_memread_i = mr[0];
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset mid-cycle, held over an edge, released; ends just after the first capture edge.
  task automatic do_reset();
    #1;
    flush_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_cnt", int'(stall_cnt_o), 0);
    chk("rst_fwd", int'({fwd_a_o, fwd_b_o}), 0);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst_i = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    model_reset();
    rst_i = 1'b1; flush_i = 1'b0;
    drv(1, 3, 1, 4, 1, 5, 1, 0);
    do_reset();

    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); step();
    // lw r3 followed by a reader of r3: stall is live, then reset lands in the middle of it
    drv(1, 1, 1, 0, 0, 3, 1, 1); tick(); step();
    drv(1, 3, 1, 5, 1, 6, 1, 0); tick();
    chk("midstall_pre", int'(stall_o), 1);
    do_reset();

`ifdef FORWARDING_EN
    // ALU chain: add r3 ; sub r4,r3,r5 ; or r8,r3,r0
    drv(1, 1, 1, 2, 1, 3, 1, 0); tick(); step();
    drv(1, 3, 1, 5, 1, 4, 1, 0); tick(); chk("alu_nostall", int'(stall_o), 0); step();
    drv(1, 3, 1, 0, 1, 8, 1, 0); tick();
    chk("alu_fwd_mem", int'(fwd_a_o), 1); chk("alu_nostall2", int'(stall_o), 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("alu_fwd_wb", int'(fwd_a_o), 2); step();
    // Priority: two writes of r7, then a read of r7 through rt
    drv(1, 1, 1, 2, 1, 7, 1, 0); tick(); step();
    drv(1, 1, 1, 2, 1, 7, 1, 0); tick(); step();
    drv(1, 0, 0, 7, 1, 9, 1, 0); tick(); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("prio_fwd_b", int'(fwd_b_o), 1); step();
    // Load-use: lw r2 ; add r6,r2,r2
    do_reset();
    drv(1, 1, 1, 0, 0, 2, 1, 1); tick(); step();
    drv(1, 2, 1, 2, 1, 6, 1, 0); tick();
    chk("lu_stall", int'(stall_o), 1); chk("lu_pcw", int'(pc_write_o), 0);
    chk("lu_bubble", int'(idex_bubble_o), 1); chk("lu_cnt0", int'(stall_cnt_o), 0); step();
    tick(); chk("lu_stall_done", int'(stall_o), 0); chk("lu_cnt1", int'(stall_cnt_o), 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("lu_fwd_a", int'(fwd_a_o), 2); chk("lu_fwd_b", int'(fwd_b_o), 2); step();
`else
    // No forwarding: add r3 then a reader of r3 stalls twice
    drv(1, 1, 1, 2, 1, 3, 1, 0); tick(); step();
    drv(1, 3, 1, 5, 1, 4, 1, 0); tick(); chk("nf_stall1", int'(stall_o), 1); step();
    tick(); chk("nf_stall2", int'(stall_o), 1); chk("nf_cnt1", int'(stall_cnt_o), 1); step();
    tick(); chk("nf_stall_end", int'(stall_o), 0); chk("nf_cnt2", int'(stall_cnt_o), 2);
    chk("nf_fwd", int'({fwd_a_o, fwd_b_o}), 0); step();
    // Reader one slot behind its producer stalls once
    drv(1, 1, 1, 2, 1, 10, 1, 0); tick(); step();
    drv(1, 1, 1, 2, 1, 11, 1, 0); tick(); step();
    drv(1, 0, 0, 10, 1, 12, 1, 0); tick(); chk("nf_gap_stall", int'(stall_o), 1); step();
    tick(); chk("nf_gap_done", int'(stall_o), 0); step();
`endif
    // r0 is never a hazard or forwarding source
    do_reset();
    drv(1, 1, 1, 0, 0, 0, 1, 1); tick(); step();
    drv(1, 0, 1, 0, 1, 6, 1, 0); tick(); chk("r0_nostall", int'(stall_o), 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("r0_fwd", int'({fwd_a_o, fwd_b_o}), 0); step();
    // Flush wins over a load-use stall and bubbles EX
    drv(1, 1, 1, 0, 0, 2, 1, 1); tick(); step();
    drv(1, 2, 1, 2, 1, 6, 1, 0); flush_i = 1'b1; tick();
    chk("fl_stall", int'(stall_o), 0); chk("fl_bubble", int'(idex_bubble_o), 1); step();
    flush_i = 1'b0; drv(1, 6, 1, 6, 1, 7, 1, 0); tick();
    chk("fl_ex_bubble_nostall", int'(stall_o), 0); step();

    // Randomized streams; ID is held while the model says the front end is stalled
    for (int b = 0; b < 12; b++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        if (last_stall == 0)
          drv(($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 2) == 0 ? 1 : 0);
        flush_i = ($urandom_range(0, 7) == 0);
        tick();
        step();
      end
    end

    // Saturation: a self-dependent load held in ID keeps stalling
    do_reset();
    drv(1, 3, 1, 0, 0, 3, 1, 1);
    for (int c = 0; c < 60; c++) begin
      tick();
      step();
    end
    tick();
    chk("cnt_saturated", int'(stall_cnt_o), CMAX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
